// File: rtl/mem_bus_bridge.sv
// rtl/mem_bus_bridge.sv - single-port memory access to request/acknowledge bus bridge
// One bus transaction per datapath access; misalignment and timeouts end in mem_err.
module mem_bus_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_req,
  input  logic        i_mem_w,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic        o_mem_stall,
  output logic        o_mem_done,
  output logic        o_mem_err,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_err
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_read_data;
  logic          r_done;
  logic          r_mem_err;
  logic          r_bus_req;
  logic          r_bus_we;
  logic [31:0]   r_bus_addr;
  logic [31:0]   r_bus_wdata;
  logic          w_aligned;

  assign w_aligned = (i_adr[1:0] == 2'b00);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_read_data <= '0;
      r_done      <= 1'b0;
      r_mem_err   <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done    <= 1'b0;
          r_mem_err <= 1'b0;
          if (i_mem_req) begin
            if (w_aligned) begin
              r_bus_addr  <= {i_adr[31:2], 2'b00};
              r_bus_we    <= i_mem_w;
              r_bus_wdata <= i_write_data;
              r_cnt       <= '0;
              r_bus_req   <= 1'b1;
              r_state     <= S_REQ;
            end else begin
              r_done    <= 1'b1;
              r_mem_err <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end
        S_REQ: begin
          // Ack wins over a timeout expiring in the same cycle.
          if (i_bus_ack) begin
            if (!r_bus_we && !i_bus_err) begin
              r_read_data <= i_bus_rdata;
            end
            r_mem_err <= i_bus_err;
            r_done    <= 1'b1;
            r_bus_req <= 1'b0;
            r_state   <= S_DONE;
          end else if (TO_EN && (r_cnt == C_LAST)) begin
            r_mem_err <= 1'b1;
            r_done    <= 1'b1;
            r_bus_req <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_done    <= 1'b0;
          r_mem_err <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_done    <= 1'b0;
          r_mem_err <= 1'b0;
          r_bus_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Stall depends only on state and mem_req, never on bus_ack.
  assign o_mem_stall = (r_state == S_REQ) | ((r_state == S_IDLE) & i_mem_req);
  assign o_read_data = r_read_data;
  assign o_mem_done  = r_done;
  assign o_mem_err   = r_mem_err;
  assign o_bus_req   = r_bus_req;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb/tb_mem_bus_bridge.sv - self-checking bench for mem_bus_bridge
// Directed vector table, randomized accesses against a transaction-level model, reset corner.
module tb_mem_bus_bridge;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] wdata_in = '0;
  logic [31:0] read_data;
  logic        mem_stall, mem_done, mem_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata = '0;
  logic        bus_err = 1'b0;

  logic        ack_en = 1'b0;
  logic        spurious = 1'b0;
  int          ack_wait = 0;
  int          req_cnt = 0;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_rd;

  always #5 clk = ~clk;

  mem_bus_bridge #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_req(mem_req), .i_mem_w(mem_w),
    .i_adr(adr), .i_write_data(wdata_in), .o_read_data(read_data),
    .o_mem_stall(mem_stall), .o_mem_done(mem_done), .o_mem_err(mem_err),
    .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
    .o_bus_wdata(bus_wdata), .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata),
    .i_bus_err(bus_err)
  );

  // Slave: counts cycles of bus_req and acks combinationally on the chosen one.
  always @(posedge clk) begin
    if (!bus_req) req_cnt <= 0;
    else          req_cnt <= req_cnt + 1;
  end
  assign bus_ack = (bus_req && ack_en && (req_cnt == ack_wait)) || spurious;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    bit          we;
    logic [31:0] wd;
    int          waits;
    bit          berr;
    logic [31:0] rd;
    bit          aen;
    int          e_lat;
    bit          e_err;
    int          e_breq;
    logic [31:0] e_rd;
  } vec_t;

  // Called at a negedge in an IDLE cycle; returns at the negedge of the following IDLE cycle.
  task automatic access(input string tag, input logic [31:0] a, input bit we,
                        input logic [31:0] wd, input int waits, input bit berr,
                        input logic [31:0] rd, input bit aen, input int e_lat,
                        input bit e_err, input int e_breq, input logic [31:0] e_rd);
    int lat = 0;
    int breq = 0;
    int stalls = 0;
    bit got_err = 1'b0;
    bit seen = 1'b0;
    ack_wait = waits; ack_en = aen; bus_rdata = rd; bus_err = berr;
    mem_req = 1'b1; mem_w = we; adr = a; wdata_in = wd;
    #1;
    if (mem_stall) stalls++;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_req) begin
        breq++;
        chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
        chk({tag, "_we"}, {31'd0, bus_we}, {31'd0, we});
        chk({tag, "_wdata"}, bus_wdata, wd);
      end
      if (mem_done) begin
        seen = 1'b1;
        lat = c;
        got_err = mem_err;
        chk({tag, "_stall_in_done"}, {31'd0, mem_stall}, 32'd0);
        mem_req = 1'b0;
      end else begin
        if (mem_stall) stalls++;
        if (mem_err) chk({tag, "_err_without_done"}, {31'd0, mem_err}, 32'd0);
      end
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    mem_req = 1'b0; ack_en = 1'b0;
    chk({tag, "_latency"}, lat, e_lat);
    chk({tag, "_err"}, {31'd0, got_err}, {31'd0, e_err});
    chk({tag, "_bus_req_cycles"}, breq, e_breq);
    chk({tag, "_stall_cycles"}, stalls, e_lat);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, mem_done}, 32'd0);
    chk({tag, "_readdata"}, read_data, e_rd);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{32'h40,  1'b0, 32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b1, 2, 1'b0, 1, 32'hDEADBEEF};
    tbl[1] = '{32'h80,  1'b1, 32'h12345678, 2, 1'b0, 32'h0BADF00D, 1'b1, 4, 1'b0, 3, 32'hDEADBEEF};
    tbl[2] = '{32'h41,  1'b0, 32'h0,        0, 1'b0, 32'h11111111, 1'b1, 1, 1'b1, 0, 32'hDEADBEEF};
    tbl[3] = '{32'h10,  1'b0, 32'h0,        0, 1'b0, 32'hAAAA5555, 1'b1, 2, 1'b0, 1, 32'hAAAA5555};
    tbl[4] = '{32'h20,  1'b0, 32'h0,        0, 1'b1, 32'h00000000, 1'b1, 2, 1'b1, 1, 32'hAAAA5555};
    tbl[5] = '{32'h30,  1'b0, 32'h0,        0, 1'b0, 32'h22222222, 1'b0, 5, 1'b1, 4, 32'hAAAA5555};
    tbl[6] = '{32'h34,  1'b0, 32'h0,        3, 1'b0, 32'h01234567, 1'b1, 5, 1'b0, 4, 32'h01234567};
    tbl[7] = '{32'h102, 1'b1, 32'hCAFEF00D, 0, 1'b0, 32'h33333333, 1'b1, 1, 1'b1, 0, 32'h01234567};
    tbl[8] = '{32'h200, 1'b1, 32'h5A5A5A5A, 1, 1'b1, 32'h44444444, 1'b1, 3, 1'b1, 2, 32'h01234567};

    repeat (3) @(negedge clk);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_done", {31'd0, mem_done}, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_readdata", read_data, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      access($sformatf("vec%0d", i), tbl[i].adr, tbl[i].we, tbl[i].wd, tbl[i].waits,
             tbl[i].berr, tbl[i].rd, tbl[i].aen, tbl[i].e_lat, tbl[i].e_err,
             tbl[i].e_breq, tbl[i].e_rd);
    end
    m_rd = 32'h01234567;

    // Spurious ack while idle must change nothing.
    spurious = 1'b1; bus_err = 1'b1; bus_rdata = 32'h55;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("spur_done", {31'd0, mem_done}, 32'd0);
      chk("spur_bus_req", {31'd0, bus_req}, 32'd0);
    end
    spurious = 1'b0; bus_err = 1'b0;
    chk("spur_readdata", read_data, m_rd);

    // Randomized accesses against a transaction-level model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, wd, rd;
      bit we, berr, aen;
      int waits, e_lat, e_breq;
      bit e_err;
      a = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      we = 1'($urandom_range(0, 1));
      wd = $urandom; rd = $urandom;
      waits = $urandom_range(0, 5);
      berr = ($urandom_range(0, 7) == 0);
      aen = ($urandom_range(0, 9) != 0);
      if (a[1:0] != 2'b00) begin
        e_breq = 0; e_lat = 1; e_err = 1'b1;
      end else if (aen && waits < TO) begin
        e_breq = waits + 1; e_lat = e_breq + 1; e_err = berr;
        if (!we && !berr) m_rd = rd;
      end else begin
        e_breq = TO; e_lat = TO + 1; e_err = 1'b1;
      end
      access($sformatf("rnd%0d", i), a, we, wd, waits, berr, rd, aen, e_lat, e_err, e_breq, m_rd);
    end

    // Reset in the middle of REQ: bus_req must drop without a clock edge.
    ack_en = 1'b0;
    mem_req = 1'b1; mem_w = 1'b0; adr = 32'h100;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_bus_req_high", {31'd0, bus_req}, 32'd1);
    #2;
    rst_n = 1'b0; mem_req = 1'b0;
    #1;
    chk("arst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("arst_done", {31'd0, mem_done}, 32'd0);
    chk("arst_err", {31'd0, mem_err}, 32'd0);
    chk("arst_we", {31'd0, bus_we}, 32'd0);
    chk("arst_addr", bus_addr, 32'd0);
    chk("arst_wdata", bus_wdata, 32'd0);
    chk("arst_readdata", read_data, 32'd0);
    chk("arst_stall", {31'd0, mem_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_done", {31'd0, mem_done}, 32'd0);
      chk("post_rst_bus_req", {31'd0, bus_req}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_bridge.md
# mem_bus_bridge

Bridges the multicycle ARM core's single memory port onto the external request/acknowledge system bus. It sits directly downstream of the control unit: it consumes the memory-write strobe and the address/write-data chosen by the datapath, and runs one bus transaction per access. While the bus is busy it stalls the main FSM, then hands back read data with a one-cycle completion pulse. It also converts misaligned accesses and unresponsive slaves into an error flag rather than a hang.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles in REQ without bus_ack before abort; 0 disables timeout.

Ports:
- clk  in  1  system clock. One clock; every register is updated on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- mem_req  in  1  datapath requests an access; held high until mem_done.
- MemW  in  1  1 = write, 0 = read; sampled with mem_req.
- Adr  in  32  byte address; sampled with mem_req.
- WriteData  in  32  store data; sampled with mem_req.
- ReadData  out  32  last completed read word.
- mem_stall  out  1  freeze main FSM / PC / IR enables.
- mem_done  out  1  one-cycle completion pulse.
- mem_err  out  1  valid with mem_done; 1 = misaligned, bus error or timeout.
- bus_req  out  1  bus transaction request.
- bus_we  out  1  bus write enable.
- bus_addr  out  32  word-aligned bus address.
- bus_wdata  out  32  bus write data.
- bus_ack  in  1  slave completion; may be combinational on bus_req.
- bus_rdata  in  32  read data; valid when bus_ack=1.
- bus_err  in  1  slave error; valid when bus_ack=1.

## Operation
- States: IDLE, REQ, DONE. Encoding is free.
- IDLE:
  - If mem_req=1 and Adr[1:0]==0: latch Adr, MemW and WriteData into bus_addr, bus_we and bus_wdata; clear the timeout counter; go to REQ.
  - If mem_req=1 and Adr[1:0]!=0: no bus transaction; set err_q=1; go to DONE.
  - Otherwise remain in IDLE.
- REQ:
  - bus_req=1. bus_addr, bus_we and bus_wdata are stable for the whole state.
  - On bus_ack=1: set err_q=bus_err. If the access is a read and bus_err=0, load ReadData from bus_rdata. Go to DONE.
  - Otherwise the counter increments. When TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack: set err_q=1; go to DONE. ReadData is unchanged.
- DONE: mem_done=1 and mem_err=err_q for exactly one cycle; go to IDLE unconditionally. mem_req is ignored in DONE.
- mem_stall = (state==REQ) | (state==IDLE & mem_req).
  - Stall is deasserted in DONE, so the FSM advances in the mem_done cycle.
  - Stall is combinational on mem_req; there is no combinational path from bus_ack to mem_stall.
- Write access: ReadData is never modified.
- Error read: ReadData keeps its previous value.
- bus_ack, bus_err and bus_rdata are ignored outside REQ. A spurious ack has no effect.
- Counter width is $clog2(TIMEOUT+1), minimum 1, and it saturates; there is no wrap.

## Timing
- Reset (reset=0, asynchronous): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, ReadData=0, mem_done=0, mem_err=0, err_q=0, counter=0.
  - Reset during REQ drops bus_req in the same instant. No mem_done is issued for the aborted access.
- Latency, with mem_req sampled in cycle N:
  - bus_req rises in N+1.
  - Ack in cycle N+k gives mem_done in N+k+1 and ReadData valid from N+k+1.
  - Minimum is 2 cycles, zero wait states (k=1).
- Misaligned access: mem_done in N+1 with mem_err=1; bus_req is never asserted.
- Timeout: bus_req is high for exactly TIMEOUT cycles; mem_done follows in the next cycle.
- bus_req falls in the cycle after ack.
- Back-to-back: a new mem_req is accepted in the IDLE cycle after DONE. Peak throughput is one access per 3 cycles.
- mem_err is 0 whenever mem_done=0.

## Test plan
- Reset values: assert reset mid-REQ with Adr=0x100 -> bus_req falls without a clock edge; all outputs reach their reset values; no mem_done after release.
- Zero-wait read: Adr=0x40, MemW=0, slave acks combinationally with rdata=0xDEADBEEF -> bus_req high for 1 cycle; mem_done 2 cycles after the request; ReadData=0xDEADBEEF; mem_err=0.
- Wait-state write: Adr=0x80, WriteData=0x12345678, ack after 3 cycles -> bus_we=1 and bus_wdata stable for 3 cycles; mem_stall high for 4 cycles; ReadData unchanged; mem_err=0.
- Misaligned: Adr=0x41 -> no bus_req; mem_done+mem_err on the next cycle.
- Timeout with TIMEOUT=4 and no ack -> bus_req high for exactly 4 cycles; then mem_done=1, mem_err=1; ReadData keeps its prior value.
- Bus error read with prior ReadData=0xAAAA5555, ack with bus_err=1 and rdata=0x0 -> mem_err=1, ReadData=0xAAAA5555. A spurious ack in IDLE changes nothing.
